// File: rtl/picorv32_trace_pkg.sv
// Shared definitions for the PicoRV32 trace capture buffer.
`default_nettype none

package picorv32_trace_pkg;

  localparam int TRACE_W = 36;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } trace_state_e;

  localparam logic [31:0] DROP_MAX = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/picorv32_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; occupancy tracked by a level counter.
`default_nettype none

module picorv32_trace_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;

  // Head is forced to zero when empty so the output is defined after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/picorv32_trace_buffer.sv
// Trace capture buffer: records core trace words until a trap, then freezes for drain.
`default_nettype none

module picorv32_trace_buffer #(
  parameter int DEPTH   = 64,
  parameter int TRACE_W = picorv32_trace_pkg::TRACE_W
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    trace_valid,
  input  logic [TRACE_W-1:0]      trace_data,
  input  logic                    trap,
  input  logic                    enable,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TRACE_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [1:0]              state,
  output logic                    overflow,
  output logic [31:0]             drop_count
);

  import picorv32_trace_pkg::*;

  trace_state_e state_q, state_d;
  logic         overflow_q, overflow_d;
  logic [31:0]  drop_cnt_q, drop_cnt_d;
  logic         push_req, push, drop, full, empty;

  // Drop decision uses pre-edge fullness, so a same-cycle pop never rescues a push.
  assign push_req = (state_q == CAPTURE) && trace_valid;
  assign push     = push_req && !full;
  assign drop     = push_req && full;

  picorv32_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (out_ready),
    .wdata_i (trace_data),
    .rdata_o (out_data),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_valid  = !empty;
  assign state      = state_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = CAPTURE;
      CAPTURE: begin
        if (trap)         state_d = FROZEN;
        else if (!enable) state_d = IDLE;
      end
      FROZEN:  if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_cnt_q == DROP_MAX) ? DROP_MAX : drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_picorv32_trace_buffer.sv
// Directed self-checking bench for picorv32_trace_buffer (DEPTH=64).
`default_nettype none

module tb_picorv32_trace_buffer;

  localparam int DEPTH = 64;
  localparam int TW    = 36;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          trace_valid = 1'b0;
  logic [TW-1:0] trace_data = '0;
  logic          trap = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [TW-1:0] out_data;
  logic [6:0]    level;
  logic [1:0]    state;
  logic          overflow;
  logic [31:0]   drop_count;

  int checks = 0;
  int failures = 0;

  picorv32_trace_buffer #(.DEPTH(DEPTH), .TRACE_W(TW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .trap        (trap),
    .enable      (enable),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .state       (state),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [TW-1:0] w);
    trace_valid = 1'b1;
    trace_data  = w;
    step();
    trace_valid = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    resetn = 1'b0;
    step();
    step();
    checks++; if (state !== 2'd0)  begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (level !== 7'd0)  begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (overflow !== 1'b0 || drop_count !== 32'd0) begin failures++; $display("FAIL reset_drop got=%b/%h exp=0/0", overflow, drop_count); end
    resetn = 1'b1;
  endtask

  task automatic test_capture();
    step();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL idle_to_capture got=%0d exp=1", state); end
    for (int i = 1; i <= 5; i++) push_word(TW'(i));
    checks++; if (level !== 7'd5) begin failures++; $display("FAIL capture_level got=%0d exp=5", level); end
    checks++; if (out_data !== 36'h1 || out_valid !== 1'b1) begin failures++; $display("FAIL capture_head got=%h/%b exp=1/1", out_data, out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL capture_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    for (int i = 6; i <= DEPTH; i++) push_word(TW'(i));
    checks++; if (level !== 7'd64 || overflow !== 1'b0) begin failures++; $display("FAIL fill_level got=%0d/%b exp=64/0", level, overflow); end
    // Pop on the last extra cycle so all three attempts see a full FIFO.
    for (int k = 0; k < 3; k++) begin
      out_ready = (k == 2);
      push_word(TW'(36'h900 + k));
      if (k == 0) begin
        checks++; if (drop_count !== 32'd1 || level !== 7'd64) begin failures++; $display("FAIL first_drop got=%0d/%0d exp=1/64", drop_count, level); end
      end
    end
    out_ready = 1'b0;
    checks++; if (drop_count !== 32'd3 || overflow !== 1'b1) begin failures++; $display("FAIL drop_count got=%0d/%b exp=3/1", drop_count, overflow); end
    checks++; if (level !== 7'd63 || out_data !== 36'h2) begin failures++; $display("FAIL level_after_pop got=%0d/%h exp=63/2", level, out_data); end
    enable = 1'b0;
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL capture_to_idle got=%0d exp=0", state); end
    out_ready = 1'b1;
    for (int i = 2; i <= DEPTH; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== TW'(i)) begin
        failures++; $display("FAIL idle_drain_%0d got=%h/%b exp=%h/1", i, out_data, out_valid, i);
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (level !== 7'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL idle_drain_empty got=%0d/%b exp=0/0", level, out_valid); end
  endtask

  task automatic test_trap();
    logic [TW-1:0] exp_w [4];
    exp_w[0] = 36'h100; exp_w[1] = 36'h101; exp_w[2] = 36'h102; exp_w[3] = 36'hABC;
    enable = 1'b1;
    step();
    for (int i = 0; i < 3; i++) push_word(exp_w[i]);
    trap = 1'b1;
    push_word(36'hABC);
    checks++; if (state !== 2'd2 || level !== 7'd4) begin failures++; $display("FAIL trap_freeze got=%0d/%0d exp=2/4", state, level); end
    trap = 1'b0;
    push_word(36'hDEF);
    trap = 1'b1;
    push_word(36'hDEF);
    trap = 1'b0;
    checks++; if (state !== 2'd2 || level !== 7'd4) begin failures++; $display("FAIL frozen_no_store got=%0d/%0d exp=2/4", state, level); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
        failures++; $display("FAIL trap_drain_%0d got=%h exp=%h", i, out_data, exp_w[i]);
      end
      step();
    end
  endtask

  task automatic test_frozen_exit();
    checks++; if (out_valid !== 1'b0 || level !== 7'd0 || state !== 2'd2) begin failures++; $display("FAIL frozen_empty got=%b/%0d/%0d exp=0/0/2", out_valid, level, state); end
    out_ready = 1'b0;
    enable = 1'b0;
    #1;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL frozen_pre_edge got=%0d exp=2", state); end
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL frozen_to_idle got=%0d exp=0", state); end
    trap = 1'b1;
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_trap got=%0d exp=0", state); end
    trap = 1'b0;
    enable = 1'b1;
    step();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL reenter_capture got=%0d exp=1", state); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < DEPTH; i++) push_word(TW'(36'h200 + i));
    for (int i = 0; i < 4; i++) push_word(36'h3FF);
    checks++; if (drop_count !== 32'd7 || level !== 7'd64) begin failures++; $display("FAIL pre_clear got=%0d/%0d exp=7/64", drop_count, level); end
    clear = 1'b1;
    out_ready = 1'b1;
    push_word(36'h777);
    clear = 1'b0;
    out_ready = 1'b0;
    checks++; if (level !== 7'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL clear_level got=%0d/%b exp=0/0", level, out_valid); end
    checks++; if (drop_count !== 32'd0 || overflow !== 1'b0) begin failures++; $display("FAIL clear_drop got=%0d/%b exp=0/0", drop_count, overflow); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL clear_state got=%0d exp=0", state); end
    step();
    push_word(36'h555);
    checks++; if (out_data !== 36'h555 || level !== 7'd1) begin failures++; $display("FAIL post_clear_push got=%h/%0d exp=555/1", out_data, level); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) push_word(TW'(36'h600 + i));
    checks++; if (level !== 7'd10) begin failures++; $display("FAIL pre_reset_level got=%0d exp=10", level); end
    out_ready = 1'b1;
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 7'd0 || state !== 2'd0) begin failures++; $display("FAIL async_reset got=%b/%0d/%0d exp=0/0/0", out_valid, level, state); end
    out_ready = 1'b0;
    step();
    resetn = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) push_word(TW'(i));
    force dut.drop_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.drop_cnt_q;
    push_word(36'h1);
    checks++; if (drop_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL drop_reach_max got=%h exp=ffffffff", drop_count); end
    push_word(36'h2);
    push_word(36'h3);
    checks++; if (drop_count !== 32'hFFFF_FFFF || overflow !== 1'b1) begin failures++; $display("FAIL drop_saturate got=%h/%b exp=ffffffff/1", drop_count, overflow); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_trap();
    test_frozen_exit();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
